// File: rtl/jelly3_img_stat_pkg.sv
// Shared types and helpers for the per-frame region statistics sink.
package jelly3_img_stat_pkg;

    // Frame tracking state: waiting for a frame start, or inside a frame.
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam int ABORT_BITS = 16;

    // Saturating increment for the abort counter.
    function automatic logic [ABORT_BITS-1:0] sat_inc(input logic [ABORT_BITS-1:0] v);
        return (v == '1) ? v : v + ABORT_BITS'(1);
    endfunction

endpackage

// File: rtl/jelly3_img_stat_acc.sv
// Per-frame accumulator: count, sum, min/max and x/y bounding box of de pixels.
// The next-state value is exported so the top can publish the frame's last
// beat in the same edge that would otherwise update the accumulator.
module jelly3_img_stat_acc #(
    parameter int X_BITS    = 11,
    parameter int Y_BITS    = 10,
    parameter int DATA_BITS = 10,
    parameter int CNT_BITS  = X_BITS + Y_BITS,
    parameter int SUM_BITS  = DATA_BITS + X_BITS + Y_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 load,
    input  logic                 clear,
    input  logic                 de,
    input  logic [DATA_BITS-1:0] data,
    input  logic [X_BITS-1:0]    x,
    input  logic [Y_BITS-1:0]    y,
    output logic [CNT_BITS-1:0]  nxt_count,
    output logic [SUM_BITS-1:0]  nxt_sum,
    output logic [DATA_BITS-1:0] nxt_min,
    output logic [DATA_BITS-1:0] nxt_max,
    output logic [X_BITS-1:0]    nxt_x_min,
    output logic [X_BITS-1:0]    nxt_x_max,
    output logic [Y_BITS-1:0]    nxt_y_min,
    output logic [Y_BITS-1:0]    nxt_y_max
);

    typedef struct packed {
        logic [CNT_BITS-1:0]  count;
        logic [SUM_BITS-1:0]  sum;
        logic [DATA_BITS-1:0] min;
        logic [DATA_BITS-1:0] max;
        logic [X_BITS-1:0]    x_min;
        logic [X_BITS-1:0]    x_max;
        logic [Y_BITS-1:0]    y_min;
        logic [Y_BITS-1:0]    y_max;
    } acc_t;

    acc_t acc_q, acc_d, base;

    // Load restarts from an empty set; the first de pixel seeds min/max/bbox.
    always_comb begin
        base  = load ? '0 : acc_q;
        acc_d = base;
        if (de) begin
            if (base.count == '0) begin
                acc_d.count = CNT_BITS'(1);
                acc_d.sum   = SUM_BITS'(data);
                acc_d.min   = data;
                acc_d.max   = data;
                acc_d.x_min = x;
                acc_d.x_max = x;
                acc_d.y_min = y;
                acc_d.y_max = y;
            end else begin
                acc_d.count = base.count + CNT_BITS'(1);
                acc_d.sum   = base.sum + SUM_BITS'(data);
                if (data < base.min)  acc_d.min   = data;
                if (data > base.max)  acc_d.max   = data;
                if (x < base.x_min)   acc_d.x_min = x;
                if (x > base.x_max)   acc_d.x_max = x;
                if (y < base.y_min)   acc_d.y_min = y;
                if (y > base.y_max)   acc_d.y_max = y;
            end
        end
    end

    // Clear after publish wins over accumulation of the publishing beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      acc_q <= '0;
        else if (clear) acc_q <= '0;
        else if (en)    acc_q <= acc_d;
    end

    assign nxt_count = acc_d.count;
    assign nxt_sum   = acc_d.sum;
    assign nxt_min   = acc_d.min;
    assign nxt_max   = acc_d.max;
    assign nxt_x_min = acc_d.x_min;
    assign nxt_x_max = acc_d.x_max;
    assign nxt_y_min = acc_d.y_min;
    assign nxt_y_max = acc_d.y_max;

endmodule

// File: rtl/jelly3_img_region_stat.sv
// Per-frame statistics sink for the region-rect stream. Tracks x/y, runs the
// frame FSM, and publishes one result per frame on a valid/ready port.
module jelly3_img_region_stat
    import jelly3_img_stat_pkg::*;
#(
    parameter int X_BITS    = 11,
    parameter int Y_BITS    = 10,
    parameter int DATA_BITS = 10,
    parameter int CNT_BITS  = X_BITS + Y_BITS,
    parameter int SUM_BITS  = DATA_BITS + X_BITS + Y_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    input  logic                  s_img_row_first,
    input  logic                  s_img_row_last,
    input  logic                  s_img_col_first,
    input  logic                  s_img_col_last,
    input  logic                  s_img_de,
    input  logic [DATA_BITS-1:0]  s_img_data,
    input  logic                  s_img_valid,
    output logic [CNT_BITS-1:0]   m_stat_count,
    output logic [SUM_BITS-1:0]   m_stat_sum,
    output logic [DATA_BITS-1:0]  m_stat_min,
    output logic [DATA_BITS-1:0]  m_stat_max,
    output logic [X_BITS-1:0]     m_stat_x_min,
    output logic [X_BITS-1:0]     m_stat_x_max,
    output logic [Y_BITS-1:0]     m_stat_y_min,
    output logic [Y_BITS-1:0]     m_stat_y_max,
    output logic                  m_stat_empty,
    output logic                  m_stat_overwrite,
    output logic                  m_stat_valid,
    input  logic                  m_stat_ready,
    output logic [ABORT_BITS-1:0] abort_count
);

    typedef struct packed {
        logic [CNT_BITS-1:0]  count;
        logic [SUM_BITS-1:0]  sum;
        logic [DATA_BITS-1:0] min;
        logic [DATA_BITS-1:0] max;
        logic [X_BITS-1:0]    x_min;
        logic [X_BITS-1:0]    x_max;
        logic [Y_BITS-1:0]    y_min;
        logic [Y_BITS-1:0]    y_max;
        logic                 empty;
    } stat_t;

    state_t                 state_q, state_d;
    logic [X_BITS-1:0]      x_q, x_d;
    logic [Y_BITS-1:0]      y_q, y_d;
    logic [ABORT_BITS-1:0]  abort_q, abort_d;
    stat_t                  stat_q, stat_d;
    logic                   valid_q, valid_d;
    logic                   ovw_q, ovw_d;

    logic beat, frm_start, frm_end;
    logic acc_en, acc_load, publish;
    stat_t nxt;

    assign beat      = cke & s_img_valid;
    assign frm_start = s_img_row_first & s_img_col_first;
    assign frm_end   = s_img_row_last & s_img_col_last;

    // Coordinates of the current beat; registered copy is the previous beat's.
    always_comb begin
        x_d = s_img_col_first ? '0 : x_q + X_BITS'(1);
        if (frm_start)            y_d = '0;
        else if (s_img_col_first) y_d = y_q + Y_BITS'(1);
        else                      y_d = y_q;
    end

    // Frame FSM decode: when to load, accumulate, abort and publish.
    always_comb begin
        state_d  = state_q;
        acc_en   = 1'b0;
        acc_load = 1'b0;
        publish  = 1'b0;
        abort_d  = abort_q;
        if (beat) begin
            case (state_q)
                IDLE: begin
                    if (frm_start) begin
                        acc_en   = 1'b1;
                        acc_load = 1'b1;
                        publish  = frm_end;
                        state_d  = frm_end ? IDLE : IN_FRAME;
                    end
                end
                IN_FRAME: begin
                    acc_en = 1'b1;
                    if (frm_start) begin
                        acc_load = 1'b1;
                        abort_d  = sat_inc(abort_q);
                    end
                    if (frm_end) begin
                        publish = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    jelly3_img_stat_acc #(
        .X_BITS(X_BITS), .Y_BITS(Y_BITS), .DATA_BITS(DATA_BITS),
        .CNT_BITS(CNT_BITS), .SUM_BITS(SUM_BITS)
    ) u_acc (
        .clk(clk), .reset(reset),
        .en(acc_en), .load(acc_load), .clear(publish),
        .de(s_img_de), .data(s_img_data), .x(x_d), .y(y_d),
        .nxt_count(nxt.count), .nxt_sum(nxt.sum),
        .nxt_min(nxt.min), .nxt_max(nxt.max),
        .nxt_x_min(nxt.x_min), .nxt_x_max(nxt.x_max),
        .nxt_y_min(nxt.y_min), .nxt_y_max(nxt.y_max)
    );
    assign nxt.empty = 1'b0;

    // Result handshake; runs every cycle regardless of cke.
    always_comb begin
        stat_d  = stat_q;
        valid_d = valid_q;
        ovw_d   = ovw_q;
        if (valid_q && m_stat_ready) valid_d = 1'b0;
        if (publish) begin
            if (nxt.count == '0) begin
                stat_d       = '0;
                stat_d.empty = 1'b1;
            end else begin
                stat_d       = nxt;
                stat_d.empty = 1'b0;
            end
            valid_d = 1'b1;
            ovw_d   = valid_q & ~m_stat_ready;
        end
    end

    // Frame state, coordinates and abort counter advance only on accepted beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            abort_q <= '0;
        end else if (beat) begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            abort_q <= abort_d;
        end
    end

    // Output result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q  <= '0;
            valid_q <= 1'b0;
            ovw_q   <= 1'b0;
        end else begin
            stat_q  <= stat_d;
            valid_q <= valid_d;
            ovw_q   <= ovw_d;
        end
    end

    assign m_stat_count     = stat_q.count;
    assign m_stat_sum       = stat_q.sum;
    assign m_stat_min       = stat_q.min;
    assign m_stat_max       = stat_q.max;
    assign m_stat_x_min     = stat_q.x_min;
    assign m_stat_x_max     = stat_q.x_max;
    assign m_stat_y_min     = stat_q.y_min;
    assign m_stat_y_max     = stat_q.y_max;
    assign m_stat_empty     = stat_q.empty;
    assign m_stat_overwrite = ovw_q;
    assign m_stat_valid     = valid_q;
    assign abort_count      = abort_q;

endmodule

// File: tb/tb_jelly3_img_region_stat.sv
// Randomized bench for jelly3_img_region_stat with a pixel-list reference model.
module tb_jelly3_img_region_stat;

    localparam int X_BITS    = 11;
    localparam int Y_BITS    = 10;
    localparam int DATA_BITS = 10;
    localparam int CNT_BITS  = X_BITS + Y_BITS;
    localparam int SUM_BITS  = DATA_BITS + X_BITS + Y_BITS;
    localparam int VW = CNT_BITS + SUM_BITS + 2*DATA_BITS + 2*X_BITS + 2*Y_BITS + 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cke = 1'b1;
    logic                 s_img_row_first = 1'b0, s_img_row_last = 1'b0;
    logic                 s_img_col_first = 1'b0, s_img_col_last = 1'b0;
    logic                 s_img_de = 1'b0;
    logic [DATA_BITS-1:0] s_img_data = '0;
    logic                 s_img_valid = 1'b0;
    logic [CNT_BITS-1:0]  m_stat_count;
    logic [SUM_BITS-1:0]  m_stat_sum;
    logic [DATA_BITS-1:0] m_stat_min, m_stat_max;
    logic [X_BITS-1:0]    m_stat_x_min, m_stat_x_max;
    logic [Y_BITS-1:0]    m_stat_y_min, m_stat_y_max;
    logic                 m_stat_empty, m_stat_overwrite, m_stat_valid;
    logic                 m_stat_ready = 1'b0;
    logic [15:0]          abort_count;

    jelly3_img_region_stat #(
        .X_BITS(X_BITS), .Y_BITS(Y_BITS), .DATA_BITS(DATA_BITS),
        .CNT_BITS(CNT_BITS), .SUM_BITS(SUM_BITS)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke),
        .s_img_row_first(s_img_row_first), .s_img_row_last(s_img_row_last),
        .s_img_col_first(s_img_col_first), .s_img_col_last(s_img_col_last),
        .s_img_de(s_img_de), .s_img_data(s_img_data), .s_img_valid(s_img_valid),
        .m_stat_count(m_stat_count), .m_stat_sum(m_stat_sum),
        .m_stat_min(m_stat_min), .m_stat_max(m_stat_max),
        .m_stat_x_min(m_stat_x_min), .m_stat_x_max(m_stat_x_max),
        .m_stat_y_min(m_stat_y_min), .m_stat_y_max(m_stat_y_max),
        .m_stat_empty(m_stat_empty), .m_stat_overwrite(m_stat_overwrite),
        .m_stat_valid(m_stat_valid), .m_stat_ready(m_stat_ready),
        .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Frame pattern and the de pixels of the frame last sent.
    logic   fde [0:15][0:15];
    int     fd  [0:15][0:15];
    typedef struct { int x; int y; int d; } pix_t;
    pix_t   pix[$];

    function automatic logic [VW-1:0] act_vec();
        return {m_stat_count, m_stat_sum, m_stat_min, m_stat_max,
                m_stat_x_min, m_stat_x_max, m_stat_y_min, m_stat_y_max,
                m_stat_empty, m_stat_overwrite};
    endfunction

    // Expected result straight from the de-pixel list of the frame.
    function automatic logic [VW-1:0] exp_vec(input bit ovw);
        longint sum = 0;
        int mn = 0, mx = 0, xmn = 0, xmx = 0, ymn = 0, ymx = 0;
        int cnt = pix.size();
        foreach (pix[i]) begin
            sum += pix[i].d;
            if (i == 0 || pix[i].d < mn) mn  = pix[i].d;
            if (i == 0 || pix[i].d > mx) mx  = pix[i].d;
            if (i == 0 || pix[i].x < xmn) xmn = pix[i].x;
            if (i == 0 || pix[i].x > xmx) xmx = pix[i].x;
            if (i == 0 || pix[i].y < ymn) ymn = pix[i].y;
            if (i == 0 || pix[i].y > ymx) ymx = pix[i].y;
        end
        return {CNT_BITS'(cnt), SUM_BITS'(sum), DATA_BITS'(mn), DATA_BITS'(mx),
                X_BITS'(xmn), X_BITS'(xmx), Y_BITS'(ymn), Y_BITS'(ymx),
                (cnt == 0), ovw};
    endfunction

    // Present one beat and hold it until accepted (cke & valid at an edge).
    task automatic beat(input bit rf, input bit rl, input bit cf, input bit cl,
                        input bit de, input int d, input bit gaps);
        int tries = 0;
        bit acc = 1'b0;
        s_img_row_first = rf; s_img_row_last = rl;
        s_img_col_first = cf; s_img_col_last = cl;
        s_img_de = de; s_img_data = DATA_BITS'(d);
        while (!acc) begin
            if (gaps && tries < 20) begin
                cke = ($urandom_range(0, 2) != 0);
                s_img_valid = ($urandom_range(0, 2) != 0);
            end else begin
                cke = 1'b1; s_img_valid = 1'b1;
            end
            @(posedge clk); #1;
            acc = cke & s_img_valid;
            tries++;
        end
        s_img_valid = 1'b0;
        cke = 1'b1;
    endtask

    task automatic fill(input int w, input int h, input int mode);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                case (mode)
                    0: begin fde[y][x] = (x >= 1 && x <= 2 && y >= 1 && y <= 2); fd[y][x] = x + 10*y; end
                    1: begin fde[y][x] = $urandom_range(0, 1); fd[y][x] = $urandom_range(0, 1023); end
                    default: begin fde[y][x] = 1'b0; fd[y][x] = $urandom_range(0, 1023); end
                endcase
            end
    endtask

    // Send the filled frame; returns just after the edge accepting the last beat.
    task automatic run_frame(input int w, input int h, input bit gaps, input bit rdy_last);
        pix.delete();
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                if (rdy_last && y == h-1 && x == w-1) m_stat_ready = 1'b1;
                beat(y == 0, y == h-1, x == 0, x == w-1, fde[y][x], fd[y][x], gaps);
                if (fde[y][x]) pix.push_back('{x, y, fd[y][x]});
            end
    endtask

    // Frame-start rows without a frame end, all pixels de.
    task automatic partial(input int w, input int rows);
        for (int y = 0; y < rows; y++)
            for (int x = 0; x < w; x++)
                beat(y == 0, 1'b0, x == 0, x == w-1, 1'b1, $urandom_range(0, 1023), 1'b0);
    endtask

    task automatic consume();
        m_stat_ready = 1'b1;
        @(posedge clk); #1;
        m_stat_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (act_vec() !== '0) $display("FAIL reset_outputs got=%h exp=0", act_vec());
        else n_pass++;
        n_chk++;
        if (m_stat_valid !== 1'b0 || abort_count !== 16'd0)
            $display("FAIL reset_valid_abort got valid=%b abort=%0d exp 0/0", m_stat_valid, abort_count);
        else n_pass++;
    endtask

    task automatic test_region();
        fill(4, 3, 0);
        n_chk++;
        if (m_stat_valid !== 1'b0) $display("FAIL region_pre_valid got=%b exp=0", m_stat_valid);
        else n_pass++;
        run_frame(4, 3, 1'b0, 1'b0);
        n_chk++;
        if (m_stat_valid !== 1'b1) $display("FAIL region_latency got valid=%b exp=1", m_stat_valid);
        else n_pass++;
        n_chk++;
        if (act_vec() !== exp_vec(1'b0)) $display("FAIL region_stats got=%h exp=%h", act_vec(), exp_vec(1'b0));
        else n_pass++;
        n_chk++;
        if (m_stat_count !== 21'd4 || m_stat_sum !== 31'd66 || m_stat_min !== 10'd11 || m_stat_max !== 10'd22)
            $display("FAIL region_golden got cnt=%0d sum=%0d min=%0d max=%0d exp 4/66/11/22",
                     m_stat_count, m_stat_sum, m_stat_min, m_stat_max);
        else n_pass++;
        consume();
    endtask

    task automatic test_empty();
        fill(4, 3, 2);
        run_frame(4, 3, 1'b0, 1'b0);
        n_chk++;
        if (act_vec() !== exp_vec(1'b0) || m_stat_valid !== 1'b1)
            $display("FAIL empty_frame got=%h valid=%b exp=%h valid=1", act_vec(), m_stat_valid, exp_vec(1'b0));
        else n_pass++;
        consume();
    endtask

    task automatic test_back_to_back();
        fill(3, 3, 1);
        run_frame(3, 3, 1'b0, 1'b0);
        n_chk++;
        if (act_vec() !== exp_vec(1'b0)) $display("FAIL b2b_first got=%h exp=%h", act_vec(), exp_vec(1'b0));
        else n_pass++;
        fill(4, 2, 1);
        run_frame(4, 2, 1'b0, 1'b0);
        n_chk++;
        if (act_vec() !== exp_vec(1'b1) || m_stat_valid !== 1'b1)
            $display("FAIL b2b_overwrite got=%h valid=%b exp=%h", act_vec(), m_stat_valid, exp_vec(1'b1));
        else n_pass++;
        fill(2, 2, 1);
        run_frame(2, 2, 1'b0, 1'b1);
        n_chk++;
        if (act_vec() !== exp_vec(1'b0) || m_stat_valid !== 1'b1)
            $display("FAIL b2b_same_cycle_accept got=%h valid=%b exp=%h valid=1", act_vec(), m_stat_valid, exp_vec(1'b0));
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (m_stat_valid !== 1'b0) $display("FAIL b2b_valid_drop got=%b exp=0", m_stat_valid);
        else n_pass++;
        m_stat_ready = 1'b0;
    endtask

    task automatic test_abort();
        partial(5, 1);
        fill(5, 3, 1);
        run_frame(5, 3, 1'b0, 1'b0);
        n_chk++;
        if (abort_count !== 16'd1) $display("FAIL abort_count got=%0d exp=1", abort_count);
        else n_pass++;
        n_chk++;
        if (act_vec() !== exp_vec(1'b0)) $display("FAIL abort_stats got=%h exp=%h", act_vec(), exp_vec(1'b0));
        else n_pass++;
        consume();
    endtask

    task automatic test_cke();
        logic [VW-1:0] ref_v;
        fill(5, 4, 1);
        run_frame(5, 4, 1'b0, 1'b0);
        ref_v = act_vec();
        consume();
        run_frame(5, 4, 1'b1, 1'b0);
        n_chk++;
        if (act_vec() !== ref_v || act_vec() !== exp_vec(1'b0))
            $display("FAIL cke_gaps got=%h exp=%h nogap=%h", act_vec(), exp_vec(1'b0), ref_v);
        else n_pass++;
        consume();
        fde[0][0] = 1'b1; fd[0][0] = 1023;
        run_frame(1, 1, 1'b0, 1'b0);
        n_chk++;
        if (act_vec() !== exp_vec(1'b0) || m_stat_valid !== 1'b1 || m_stat_min !== 10'd1023 || m_stat_count !== 21'd1)
            $display("FAIL single_pixel got=%h valid=%b exp=%h", act_vec(), m_stat_valid, exp_vec(1'b0));
        else n_pass++;
        consume();
    endtask

    task automatic test_reset_mid();
        partial(4, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (act_vec() !== '0 || m_stat_valid !== 1'b0 || abort_count !== 16'd0)
            $display("FAIL reset_mid_clear got=%h valid=%b abort=%0d exp 0", act_vec(), m_stat_valid, abort_count);
        else n_pass++;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (m_stat_valid !== 1'b0) $display("FAIL reset_mid_no_result got valid=%b exp=0", m_stat_valid);
        else n_pass++;
        fill(6, 4, 1);
        run_frame(6, 4, 1'b1, 1'b0);
        n_chk++;
        if (act_vec() !== exp_vec(1'b0) || m_stat_valid !== 1'b1)
            $display("FAIL reset_mid_next got=%h valid=%b exp=%h", act_vec(), m_stat_valid, exp_vec(1'b0));
        else n_pass++;
        consume();
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int w = $urandom_range(1, 16);
            int h = $urandom_range(1, 12);
            fill(w, h, 1);
            run_frame(w, h, i[0], 1'b0);
            n_chk++;
            if (act_vec() !== exp_vec(1'b0) || m_stat_valid !== 1'b1)
                $display("FAIL random_frame_%0d got=%h exp=%h", i, act_vec(), exp_vec(1'b0));
            else n_pass++;
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_region();
        test_empty();
        test_back_to_back();
        test_abort();
        test_cke();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
